lives_ctl: RTL and testbench
============================

Name: lives_ctl

Overview:
Lives and respawn controller for the player ship. It counts hits from the collision logic and drives the dead_count value consumed by the lives-icon draw stages. It also sequences a frame-timed invulnerability and blink window after each hit, and a game-over state. It sits between collision detection and the ship and lives draw chain, and runs on the pixel clock with frame timing taken from vsync.

Parameters:
LIVES, 3, number of lives (1..15); game over when dead_count reaches LIVES
INVULN_FRAMES, 120, frames of invulnerability after a non-fatal hit (1..1023)
BLINK_FRAMES, 8, frames per visibility half-period during invulnerability (1..63)

Ports:
pclk  input  1  pixel clock; the only clock
rst  input  1  synchronous reset, active-high
vsync_in  input  1  vertical sync from the timing chain; each rising edge is one frame tick
hit  input  1  single-cycle pulse from collision logic: ship hit
restart  input  1  single-cycle pulse: start a new game
extra_life  input  1  single-cycle pulse: award one life (used only with LIVES_CTL_EXTRA_LIFE_EN)
dead_count  output  4  lives lost so far, 0..LIVES
ship_visible  output  1  ship draw enable (blink gating)
invuln  output  1  high while hits are ignored
game_over  output  1  high in GAME_OVER
hit_ack  output  1  one-cycle pulse: a hit was accepted

Behaviour:
- All outputs are registered. Reset values: dead_count=0, ship_visible=1, invuln=0, game_over=0, hit_ack=0. Reset state is PLAY, all counters are 0, and vsync_d=0.
- rst asserted in any state, including mid-invulnerability, returns everything to these reset values on the next edge.
- Frame tick: frame_tick = vsync_in & ~vsync_d, with vsync_d registered each cycle. It is a one-cycle pulse, one per frame.
- State machine states: PLAY, INVULN, GAME_OVER.
- PLAY, hit=1:
  - hit_ack pulses and dead_count increments on the next edge (latency 1).
  - If dead_count+1 == LIVES, go to GAME_OVER.
  - Otherwise go to INVULN: frame_cnt = INVULN_FRAMES-1, blink_cnt = BLINK_FRAMES-1, ship_visible = 0.
- INVULN:
  - invuln=1. Hits are ignored: no hit_ack, no count change.
  - On each frame_tick: if blink_cnt==0, toggle ship_visible and reload blink_cnt = BLINK_FRAMES-1; otherwise decrement blink_cnt.
  - On each frame_tick: if frame_cnt==0, go to PLAY with ship_visible=1 and invuln=0; otherwise decrement frame_cnt.
  - Duration is exactly INVULN_FRAMES frame ticks after entry. A tick in the same cycle as entry is not counted.
- GAME_OVER:
  - game_over=1, ship_visible=0, invuln=0, dead_count holds at LIVES.
  - hit and extra_life are ignored.
- restart, in any state:
  - On the next edge: PLAY, dead_count=0, ship_visible=1, invuln=0, game_over=0, counters cleared.
  - restart has priority over a same-cycle hit or extra_life; no hit_ack is produced.
- Same-cycle hit and frame_tick in PLAY: the hit is processed. The new INVULN counters do not decrement on that tick.
- Widths: frame_cnt is 10 bits, blink_cnt is 6 bits.
- dead_count never exceeds LIVES and never wraps below 0.

Optional Feature:
LIVES_CTL_EXTRA_LIFE_EN.
- Defined: an extra_life pulse in PLAY or INVULN decrements dead_count by 1 on the next edge, saturating at 0. State is not changed.
  - A hit and extra_life in the same cycle in PLAY: the hit is applied and extra_life is dropped, so the net change is +1.
  - In INVULN, extra_life alone is applied.
- Not defined: the extra_life input is unused and has no effect on any output or state.

Test Plan:
- Reset, then idle for 3 frames -> dead_count=0, ship_visible=1, invuln=0, game_over=0.
- One hit pulse in PLAY -> hit_ack high exactly 1 cycle later, dead_count=1, invuln=1, ship_visible=0. Toggles every 8 ticks. invuln falls after tick 120, ship_visible=1.
- Hit, then a second hit 5 frames later during INVULN -> no hit_ack, dead_count stays 1.
- Three hits, each after the invulnerability window expires (LIVES=3) -> after the 3rd: dead_count=3, game_over=1, ship_visible=0. A 4th hit leaves dead_count=3.
- In GAME_OVER, assert restart and hit in the same cycle -> next cycle dead_count=0, game_over=0, no hit_ack. Also assert rst mid-INVULN at frame 50 -> all outputs at reset values next cycle.
- With LIVES_CTL_EXTRA_LIFE_EN: dead_count=2, pulse extra_life -> dead_count=1. At 0, pulse extra_life -> stays 0. Without the macro, the same stimulus -> dead_count unchanged.

Source files
------------

// File: rtl/lives_ctl.sv
// Lives / respawn controller: hit counting, frame-timed invulnerability blink, game over.
// Optional extra-life support is enabled by defining LIVES_CTL_EXTRA_LIFE_EN.
module lives_ctl #(
   parameter int LIVES         = 3,
   parameter int INVULN_FRAMES = 120,
   parameter int BLINK_FRAMES  = 8
) (
   input  logic       pclk,
   input  logic       rst,
   input  logic       vsync_in,
   input  logic       hit,
   input  logic       restart,
   input  logic       extra_life,
   output logic [3:0] dead_count,
   output logic       ship_visible,
   output logic       invuln,
   output logic       game_over,
   output logic       hit_ack
);

   localparam logic [3:0] LIVES_W = 4'(LIVES);
   localparam logic [9:0] FRM_TOP = 10'(INVULN_FRAMES - 1);
   localparam logic [5:0] BLK_TOP = 6'(BLINK_FRAMES - 1);

   typedef enum logic [1:0] {
      PLAY      = 2'd0,
      INVULN    = 2'd1,
      GAME_OVER = 2'd2
   } state_t;

   state_t     state;
   logic       vsync_d;
   logic [9:0] frame_cnt;
   logic [5:0] blink_cnt;
   logic       frame_tick;
   logic       el_req;
   logic [3:0] dead_inc;

   assign frame_tick = vsync_in & ~vsync_d;
   assign dead_inc   = dead_count + 4'd1;

`ifdef LIVES_CTL_EXTRA_LIFE_EN
   assign el_req = extra_life && (dead_count != 4'd0);
`else
   logic unused_extra_life;
   assign unused_extra_life = extra_life;
   assign el_req = 1'b0;
`endif

   always_ff @(posedge pclk) begin
      if (rst) begin
         state        <= PLAY;
         vsync_d      <= 1'b0;
         frame_cnt    <= '0;
         blink_cnt    <= '0;
         dead_count   <= '0;
         ship_visible <= 1'b1;
         invuln       <= 1'b0;
         game_over    <= 1'b0;
         hit_ack      <= 1'b0;
      end else begin
         vsync_d <= vsync_in;
         hit_ack <= 1'b0;
         if (restart) begin
            state        <= PLAY;
            frame_cnt    <= '0;
            blink_cnt    <= '0;
            dead_count   <= '0;
            ship_visible <= 1'b1;
            invuln       <= 1'b0;
            game_over    <= 1'b0;
         end else begin
            unique case (state)
               PLAY: begin
                  if (hit) begin
                     hit_ack    <= 1'b1;
                     dead_count <= dead_inc;
                     if (dead_inc == LIVES_W) begin
                        state        <= GAME_OVER;
                        game_over    <= 1'b1;
                        ship_visible <= 1'b0;
                        invuln       <= 1'b0;
                     end else begin
                        state        <= INVULN;
                        frame_cnt    <= FRM_TOP;
                        blink_cnt    <= BLK_TOP;
                        ship_visible <= 1'b0;
                        invuln       <= 1'b1;
                     end
                  end else if (el_req) begin
                     dead_count <= dead_count - 4'd1;
                  end
               end
               INVULN: begin
                  if (el_req)
                     dead_count <= dead_count - 4'd1;
                  if (frame_tick) begin
                     if (frame_cnt == 10'd0) begin
                        state        <= PLAY;
                        ship_visible <= 1'b1;
                        invuln       <= 1'b0;
                        blink_cnt    <= '0;
                     end else begin
                        frame_cnt <= frame_cnt - 10'd1;
                        if (blink_cnt == 6'd0) begin
                           ship_visible <= ~ship_visible;
                           blink_cnt    <= BLK_TOP;
                        end else begin
                           blink_cnt <= blink_cnt - 6'd1;
                        end
                     end
                  end
               end
               GAME_OVER: begin
                  dead_count   <= LIVES_W;
                  game_over    <= 1'b1;
                  ship_visible <= 1'b0;
                  invuln       <= 1'b0;
               end
               default: state <= PLAY;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_lives_ctl.sv
// Directed bench for lives_ctl with default parameters (3 lives, 120/8 frames).
// Extra-life expectations follow LIVES_CTL_EXTRA_LIFE_EN when defined.
module tb_lives_ctl;

   logic       pclk = 1'b0;
   logic       rst = 1'b1;
   logic       vsync_in = 1'b0;
   logic       hit = 1'b0;
   logic       restart = 1'b0;
   logic       extra_life = 1'b0;
   logic [3:0] dead_count;
   logic       ship_visible;
   logic       invuln;
   logic       game_over;
   logic       hit_ack;

   int n_tests = 0;
   int n_fail  = 0;

`ifdef LIVES_CTL_EXTRA_LIFE_EN
   localparam int EL = 1;
`else
   localparam int EL = 0;
`endif

   lives_ctl dut (
      .pclk        (pclk),
      .rst         (rst),
      .vsync_in    (vsync_in),
      .hit         (hit),
      .restart     (restart),
      .extra_life  (extra_life),
      .dead_count  (dead_count),
      .ship_visible(ship_visible),
      .invuln      (invuln),
      .game_over   (game_over),
      .hit_ack     (hit_ack)
   );

   always #5 pclk = ~pclk;

   task automatic check(input string tag, input int got, input int exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic check_all(input string tag, input int dc, input int vis,
                            input int inv, input int go, input int ack);
      check({tag, ".dead"}, int'(dead_count), dc);
      check({tag, ".vis"}, int'(ship_visible), vis);
      check({tag, ".inv"}, int'(invuln), inv);
      check({tag, ".go"}, int'(game_over), go);
      check({tag, ".ack"}, int'(hit_ack), ack);
   endtask

   task automatic pulse(input logic h, input logic r, input logic e);
      @(negedge pclk);
      hit = h; restart = r; extra_life = e;
      @(negedge pclk);
      hit = 1'b0; restart = 1'b0; extra_life = 1'b0;
   endtask

   task automatic frames(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge pclk);
         vsync_in = 1'b1;
         @(negedge pclk);
         vsync_in = 1'b0;
      end
   endtask

   initial begin
      repeat (2) @(negedge pclk);
      rst = 1'b0;
      check_all("reset", 0, 1, 0, 0, 0);
      frames(3);
      check_all("idle3", 0, 1, 0, 0, 0);

      pulse(1, 0, 0);
      check_all("hit1", 1, 0, 1, 0, 1);
      @(negedge pclk);
      check("hit1.ack_drop", int'(hit_ack), 0);
      frames(7);
      check("blink.t7", int'(ship_visible), 0);
      frames(1);
      check("blink.t8", int'(ship_visible), 1);
      frames(8);
      check("blink.t16", int'(ship_visible), 0);
      frames(103);
      check("inv.t119", int'(invuln), 1);
      check("vis.t119", int'(ship_visible), 0);
      frames(1);
      check_all("inv.t120", 1, 1, 0, 0, 0);

      pulse(1, 0, 0);
      check_all("hit2", 2, 0, 1, 0, 1);
      frames(5);
      pulse(1, 0, 0);
      check("ignored.ack", int'(hit_ack), 0);
      check("ignored.dead", int'(dead_count), 2);
      frames(115);
      check("win2.inv", int'(invuln), 0);

      pulse(0, 0, 1);
      check("el.from2", int'(dead_count), 2 - EL);
      pulse(0, 1, 0);
      check_all("restart", 0, 1, 0, 0, 0);
      pulse(0, 0, 1);
      check("el.at0", int'(dead_count), 0);

      pulse(1, 0, 0);
      frames(120);
      pulse(1, 0, 0);
      frames(120);
      check_all("pre_go", 2, 1, 0, 0, 0);
      pulse(1, 0, 0);
      check_all("go", 3, 0, 0, 1, 1);
      pulse(1, 0, 0);
      check_all("go.hit4", 3, 0, 0, 1, 0);
      pulse(0, 0, 1);
      check("go.el", int'(dead_count), 3);

      pulse(1, 1, 0);
      check_all("go.restart_hit", 0, 1, 0, 0, 0);

      pulse(1, 0, 0);
      frames(50);
      check("mid.inv", int'(invuln), 1);
      @(negedge pclk);
      rst = 1'b1;
      @(negedge pclk);
      rst = 1'b0;
      check_all("rst_mid", 0, 1, 0, 0, 0);

      @(negedge pclk);
      hit = 1'b1; vsync_in = 1'b1;
      @(negedge pclk);
      hit = 1'b0; vsync_in = 1'b0;
      check_all("hit_tick", 1, 0, 1, 0, 1);
      frames(119);
      check("hit_tick.t119", int'(invuln), 1);
      frames(1);
      check("hit_tick.t120", int'(invuln), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
